// File: rtl/cpu_pkg.sv
// Shared types and default widths for the memory port arbiter.
package cpu_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2,
    DONE     = 2'd3
  } arb_state_e;
endpackage

// File: rtl/arb_rr2.sv
// Two-requester grant logic: DM wins a tie unless it won the previous one,
// so contended IF/DM requests alternate. Grants only fire when i_en is high.
module arb_rr2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic i_en,
  input  logic i_if_req,
  input  logic i_dm_req,
  output logic o_grant_if,
  output logic o_grant_dm
);
  logic r_last_dm;

  // Grant decision from current requests and the alternation bit
  always_comb begin
    o_grant_dm = i_en & i_dm_req & (~i_if_req | ~r_last_dm);
    o_grant_if = i_en & i_if_req & ~o_grant_dm;
  end

  // Remember who got the most recent grant
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)        r_last_dm <= 1'b0;
    else if (o_grant_dm) r_last_dm <= 1'b1;
    else if (o_grant_if) r_last_dm <= 1'b0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch (IF) and data (DM)
// requesters. One access in flight: IDLE -> SERVE_* -> DONE -> IDLE.
// Optional feature: define MEM_ARB_STATS_EN to add conflict_cnt_o, a
// wrapping count of IDLE cycles where both requesters were asking.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_valid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       conflict_cnt_o
`endif
);
  arb_state_e        r_state, w_state_nxt;
  logic              w_idle, w_serve, w_grant_if, w_grant_dm;
  logic              r_mem_req, r_mem_we, r_if_valid, r_dm_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_dm_rdata;

  assign w_idle  = (r_state == IDLE);
  assign w_serve = (r_state == SERVE_IF) || (r_state == SERVE_DM);

  arb_rr2 u_arb (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .i_en       (w_idle),
    .i_if_req   (if_req_i),
    .i_dm_req   (dm_req_i),
    .o_grant_if (w_grant_if),
    .o_grant_dm (w_grant_dm)
  );

  // Next-state: ready is only meaningful while serving
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_dm)      w_state_nxt = SERVE_DM;
        else if (w_grant_if) w_state_nxt = SERVE_IF;
      end
      SERVE_IF, SERVE_DM: if (mem_ready_i) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Request latch on grant, completion capture on ready; valids live only in DONE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      if (w_grant_dm) begin
        r_mem_req <= 1'b1;
        r_mem_we  <= dm_we_i;
        r_addr    <= dm_addr_i;
        r_wdata   <= dm_wdata_i;
      end else if (w_grant_if) begin
        r_mem_req <= 1'b1;
        r_mem_we  <= 1'b0;
        r_addr    <= if_addr_i;
        r_wdata   <= '0;
      end else if (w_serve && mem_ready_i) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        if (r_state == SERVE_DM) begin
          r_dm_valid <= 1'b1;
          // Writes complete without disturbing the last read data
          if (!r_mem_we) r_dm_rdata <= mem_rdata_i;
        end else begin
          r_if_valid <= 1'b1;
          r_if_rdata <= mem_rdata_i;
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_conflict_cnt;

  // Count contended IDLE cycles; natural wrap at 2^32
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                           r_conflict_cnt <= '0;
    else if (w_idle && if_req_i && dm_req_i) r_conflict_cnt <= r_conflict_cnt + 32'd1;
  end

  assign conflict_cnt_o = r_conflict_cnt;
`endif

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign if_valid_o  = r_if_valid;
  assign dm_valid_o  = r_dm_valid;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign stall_if_o  = if_req_i & ~r_if_valid;
  assign stall_mem_o = dm_req_i & ~r_dm_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
// Define MEM_ARB_STATS_EN to also exercise conflict_cnt_o.
module tb_mem_port_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_valid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0, dm_wdata_i = '0;
  logic        dm_valid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_if_o, stall_mem_o;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] conflict_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
`ifdef MEM_ARB_STATS_EN
    , .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: one outstanding access; a finished access shows its
  // valid for one cycle, after which the port is free for a new grant.
  logic        m_busy, m_done, m_dm, m_last, m_we;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd, m_cnt;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dm <= 1'b0; m_last <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_if_rd <= '0; m_dm_rd <= '0; m_cnt <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (mem_ready_i) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        if (!m_dm)      m_if_rd <= mem_rdata_i;
        else if (!m_we) m_dm_rd <= mem_rdata_i;
      end
    end else begin
      if (if_req_i && dm_req_i) m_cnt <= m_cnt + 32'd1;
      if (dm_req_i && !(if_req_i && m_last)) begin
        m_busy <= 1'b1; m_dm <= 1'b1; m_last <= 1'b1;
        m_we <= dm_we_i; m_addr <= dm_addr_i; m_wdata <= dm_wdata_i;
      end else if (if_req_i) begin
        m_busy <= 1'b1; m_dm <= 1'b0; m_last <= 1'b0;
        m_we <= 1'b0; m_addr <= if_addr_i; m_wdata <= '0;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(posedge clk_i) begin
    #1;
    chk("mem_req", {31'd0, mem_req_o}, {31'd0, m_busy});
    chk("mem_we", {31'd0, mem_we_o}, {31'd0, m_busy & m_we});
    if (m_busy) chk("mem_addr", mem_addr_o, m_addr);
    if (m_busy && m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
    chk("if_valid", {31'd0, if_valid_o}, {31'd0, m_done & ~m_dm});
    chk("dm_valid", {31'd0, dm_valid_o}, {31'd0, m_done & m_dm});
    chk("if_rdata", if_rdata_o, m_if_rd);
    chk("dm_rdata", dm_rdata_o, m_dm_rd);
    chk("stall_if", {31'd0, stall_if_o}, {31'd0, if_req_i & ~(m_done & ~m_dm)});
    chk("stall_mem", {31'd0, stall_mem_o}, {31'd0, dm_req_i & ~(m_done & m_dm)});
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; mem_ready_i = 1'b0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_valids", {30'd0, if_valid_o, dm_valid_o}, 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);

    // IF-only read, zero-wait memory
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h10;
    tick();
    chk("if_rd_req", {31'd0, mem_req_o}, 32'd1);
    chk("if_rd_addr", mem_addr_o, 32'h10);
    chk("if_rd_we", {31'd0, mem_we_o}, 32'd0);
    @(negedge clk_i);
    mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    chk("if_rd_valid", {31'd0, if_valid_o}, 32'd1);
    chk("if_rd_data", if_rdata_o, 32'hDEADBEEF);
    chk("if_rd_req_drop", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk_i);
    if_req_i = 1'b0; mem_ready_i = 1'b0;
    tick();
    chk("if_rd_valid_1cyc", {31'd0, if_valid_o}, 32'd0);
    chk("if_rd_stall", {31'd0, stall_if_o}, 32'd0);

    // Contention from reset: DM first, then alternating
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    dm_req_i = 1'b1; dm_addr_i = 32'h200; dm_we_i = 1'b0;
    mem_ready_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("alt_grant_addr", mem_addr_o, (g % 2 == 0) ? 32'h200 : 32'h100);
      tick();
      tick();
    end
`ifdef MEM_ARB_STATS_EN
    chk("conflict_cnt5", conflict_cnt_o, 32'd5);
`endif
    @(negedge clk_i);
    if_req_i = 1'b0; dm_req_i = 1'b0; mem_ready_i = 1'b0;

    // DM write with four wait cycles
    do_reset();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'h5A5A5A5A;
    mem_rdata_i = 32'h1234;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wr_addr", mem_addr_o, 32'h20);
      chk("wr_wdata", mem_wdata_o, 32'h5A5A5A5A);
      chk("wr_we_req", {30'd0, mem_we_o, mem_req_o}, 32'd3);
      chk("wr_no_valid", {31'd0, dm_valid_o}, 32'd0);
      if (i == 4) begin
        @(negedge clk_i);
        mem_ready_i = 1'b1;
      end
      tick();
    end
    chk("wr_valid", {31'd0, dm_valid_o}, 32'd1);
    chk("wr_rdata_kept", dm_rdata_o, 32'd0);
    @(negedge clk_i);
    dm_req_i = 1'b0; mem_ready_i = 1'b0;
    tick();
    chk("wr_valid_1cyc", {31'd0, dm_valid_o}, 32'd0);

    // Reset in the middle of a DM access
    do_reset();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h30;
    tick();
    chk("abort_req_before", {31'd0, mem_req_o}, 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("abort_req_async", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk_i);
    dm_req_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_valid", {30'd0, dm_valid_o, mem_req_o}, 32'd0);
    end

    // Stray ready while idle
    do_reset();
    mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ready_ignored", {29'd0, mem_req_o, if_valid_o, dm_valid_o}, 32'd0);
    end

`ifdef MEM_ARB_STATS_EN
    // Counter wrap from all-ones
    do_reset();
    force dut.r_conflict_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_conflict_cnt;
    if_req_i = 1'b1; dm_req_i = 1'b1; mem_ready_i = 1'b1;
    tick();
    chk("conflict_wrap", conflict_cnt_o, 32'd0);
    @(negedge clk_i);
    if_req_i = 1'b0; dm_req_i = 1'b0;
    tick(); tick();
`endif

    // Random traffic; requesters hold until their valid pulse
    do_reset();
    repeat (2000) begin
      @(negedge clk_i);
      if (if_req_i && if_valid_o) if_req_i = 1'b0;
      else if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i = 1'b1; if_addr_i = $urandom;
      end
      if (dm_req_i && dm_valid_o) dm_req_i = 1'b0;
      else if (!dm_req_i && $urandom_range(0, 2) == 0) begin
        dm_req_i = 1'b1; dm_we_i = 1'($urandom_range(0, 1));
        dm_addr_i = $urandom; dm_wdata_i = $urandom;
      end
      mem_ready_i = ($urandom_range(0, 2) != 0);
      mem_rdata_i = $urandom;
    end
    tick();
`ifdef MEM_ARB_STATS_EN
    chk("conflict_cnt_rand", conflict_cnt_o, m_cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
